// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit. It handles signed and unsigned multiply
//   (shift-add, full double-width product) and signed and unsigned divide
//   (restoring division). It performs one iteration per clock and takes
//   WIDTH iterations per operation. A divide by zero bypasses the datapath
//   and completes with dz set.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands are latched on the accepting edge
//   CALC  | iterating; cnt counts down to the final iteration
//   DONE  | one-cycle completion pulse; dz is valid here
//
// Ports
//   clk    : clock, rising-edge active
//   rst    : asynchronous active-high reset
//   start  : request a new operation (sampled only in IDLE)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b   : rs / rt operands
//   busy   : high in CALC and DONE
//   done   : one-cycle completion pulse
//   dz     : divide-by-zero flag, only meaningful while done is high
//   hi, lo : result registers (product upper/lower, or remainder/quotient)
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand;

  // Operand magnitudes at the start edge; unsigned ops never negate.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One datapath step. Multiply shifts the partial product right; divide
  // shifts the remainder/quotient pair left and keeps the trial difference
  // when it does not borrow.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};

  always_comb begin
    nxt_hi = '0;
    nxt_lo = '0;
    if (is_div) begin
      nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction is applied to the final step's outputs so the result
  // lands in hi/lo on the same edge that CALC ends.
  assign prod     = {nxt_hi, nxt_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -nxt_lo : nxt_lo;
  assign rem_fix  = neg_rem ? -nxt_hi : nxt_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          dz <= 1'b0;
          if (start) begin
            if (op[1] && (b == '0)) begin
              dz    <= 1'b1;
              state <= S_DONE;
            end else begin
              state   <= S_CALC;
              cnt     <= CNT_W'(WIDTH - 1);
              is_div  <= op[1];
              neg_res <= a_neg ^ b_neg;
              neg_rem <= op[1] & a_neg;
              acc_hi  <= '0;
              acc_lo  <= op[1] ? a_mag : b_mag;
              mcand   <= op[1] ? b_mag : a_mag;
            end
          end
        end
        S_CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == '0) begin
            hi    <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo    <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            state <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          dz    <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          dz    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic. SV '/' and '%' on
  // signed values truncate toward zero and give the remainder the sign of
  // the dividend, exactly the required semantics; 64 bits keep MIN/-1 exact.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    e.hi = m_hi;
    e.lo = m_lo;
    e.cyc = 0;
    case (o)
      2'b00: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == '0) begin
          e.dz = 1'b1;
        end else begin
          if (o == 2'b10) begin
            q = sx / sy;
            r = sx % sy;
          end else begin
            q = longint'({32'b0, x}) / longint'({32'b0, y});
            r = longint'({32'b0, x}) % longint'({32'b0, y});
          end
          p = 64'(q); e.lo = p[31:0];
          p = 64'(r); e.hi = p[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse, and checks that the unit
  // is idle in the cycle after each done.
  logic chk_idle = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", {63'b0, busy}, 64'd0);
        chk_idle = 1'b0;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("hi", {32'b0, hi}, {32'b0, e.hi});
          check("lo", {32'b0, lo}, {32'b0, e.lo});
          check("dz", {63'b0, dz}, {63'b0, e.dz});
          check("latency", 64'(cyc), 64'(e.cyc));
        end
        chk_idle = 1'b1;
      end else if (dz) begin
        check("dz_without_done", {63'b0, dz}, 64'd0);
      end
    end
  end

  // Issue one operation starting at a negedge; returns at the negedge after
  // the start edge with start dropped and operands scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    e = model(o, x, y);
    e.cyc = cyc + 1 + (e.dz ? 0 : W);
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           k;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dz", {63'b0, dz}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(2'b11, 32'd7, 32'd2);
    issue(2'b11, 32'h0000_0451, 32'h0000_0020);
    issue(2'b11, 32'h1234_5678, 32'h0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    issue(2'b10, 32'h8000_0000, 32'h0);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);

    // Start while busy and start on the DONE->IDLE edge must both be ignored.
    issue(2'b00, 32'hFFFF_FFF3, 32'h0000_1234);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      k  = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      case (k)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 40)); rb = 32'($urandom_range(1, 9)); end
        3: rb = 32'($signed($urandom_range(0, 10)) - 5);
        default: ;
      endcase
      issue(ro, ra, rb);
    end

    // Abort a divide with reset partway through.
    issue(2'b10, 32'h7654_3210, 32'h0000_0123);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b01, 32'd5, 32'd6);

    k = 0;
    while ((sb_q.size() != 0 || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
